// File: rtl/fetch_unit.sv
// fetch_unit: PC sequencing and instruction fetch for the MIPS core.
// Fetches one instruction at a time over a ready handshake, holds it
// for decode/execute, then selects the next PC from the jump and branch
// controls.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   imem_addr/req     fetch request (address = pc), raised in S_FETCH
//   imem_ready/rdata  fetch response, sampled only in S_FETCH
//   instr/instr_valid registered instruction, valid in S_EXEC
//   pc, pcplus4       address of instr and its sequential successor
//   branch/jump/zero  next-PC controls, sampled only in S_EXEC
//   stall             holds the current instruction in S_EXEC
//   instret           retired-instruction counter
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pcplus4,
    input  logic        branch,
    input  logic        jump,
    input  logic        zero,
    input  logic        stall,
    output logic [31:0] instret
);

    typedef enum logic [1:0] {
        S_RESET,
        S_FETCH,
        S_EXEC
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_instret;
    logic [31:0] w_pcplus4;
    logic [31:0] w_br_off;
    logic [31:0] w_br_tgt;
    logic [31:0] w_jmp_tgt;
    logic [31:0] w_next_pc;
    logic        w_take;
    logic        w_retire;

    assign w_pcplus4 = r_pc + 32'd4;
    assign w_br_off  = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
    assign w_br_tgt  = w_pcplus4 + w_br_off;
    assign w_jmp_tgt = {w_pcplus4[31:28], r_instr[25:0], 2'b00};

    // Jump wins over a taken branch.
    always_comb begin
        w_next_pc = w_pcplus4;
        if (jump) begin
            w_next_pc = w_jmp_tgt;
        end else if (branch && zero) begin
            w_next_pc = w_br_tgt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        w_take      = 1'b0;
        w_retire    = 1'b0;
        unique case (r_state)
            S_RESET: begin
                w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    w_take      = 1'b1;
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                instr_valid = 1'b1;
                if (!stall) begin
                    w_retire    = 1'b1;
                    w_state_nxt = S_FETCH;
                end
            end
            default: begin
                w_state_nxt = S_RESET;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_RESET;
            r_pc      <= RESET_PC;
            r_instr   <= 32'd0;
            r_instret <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_take) begin
                r_instr <= imem_rdata;
            end
            if (w_retire) begin
                r_pc      <= w_next_pc;
                r_instret <= r_instret + 32'd1;
            end
        end
    end

    assign imem_addr = r_pc;
    assign instr     = r_instr;
    assign pc        = r_pc;
    assign pcplus4   = w_pcplus4;
    assign instret   = r_instret;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scenario tasks with a fetch/retire scoreboard.
// A second instance starts at the top of the address space.
module tb_fetch_unit;

    localparam logic [31:0] RPC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        branch, jump, zero, stall;

    logic [31:0] imem_addr, instr, pc, pcplus4, instret;
    logic        imem_req, instr_valid;

    logic [31:0] imem_addr2, instr2, pc2, pcplus42, instret2;
    logic        imem_req2, instr_valid2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } sb_t;

    sb_t         q[$];
    int          errs = 0;
    int          checks = 0;
    logic [31:0] m_pc;
    logic [31:0] m_cnt;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RPC)) dut (
        .clk(clk), .reset(reset),
        .imem_addr(imem_addr), .imem_req(imem_req),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .instr(instr), .instr_valid(instr_valid),
        .pc(pc), .pcplus4(pcplus4),
        .branch(branch), .jump(jump), .zero(zero), .stall(stall),
        .instret(instret)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .reset(reset),
        .imem_addr(imem_addr2), .imem_req(imem_req2),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .instr(instr2), .instr_valid(instr_valid2),
        .pc(pc2), .pcplus4(pcplus42),
        .branch(branch), .jump(jump), .zero(zero), .stall(stall),
        .instret(instret2)
    );

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] model_next(
        input logic [31:0] p, input logic [31:0] i,
        input bit b, input bit j, input bit z);
        logic [31:0] p4;
        p4 = p + 32'd4;
        if (j) return {p4[31:28], i[25:0], 2'b00};
        if (b && z) return p4 + {{14{i[15]}}, i[15:0], 2'b00};
        return p4;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        cyc();
        cyc();
        checks++;
        if (pc !== RPC || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            errs++;
            $display("FAIL reset_out: pc=%h req=%b v=%b want pc=%h req=0 v=0",
                     pc, imem_req, instr_valid, RPC);
        end
        checks++;
        if (instr !== 32'd0 || instret !== 32'd0) begin
            errs++;
            $display("FAIL reset_regs: instr=%h instret=%h want 0 0",
                     instr, instret);
        end
        checks++;
        if (pcplus42 !== 32'h0000_0000) begin
            errs++;
            $display("FAIL pc4_wrap: got %h want 00000000", pcplus42);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            errs++;
            $display("FAIL exit_noreq: req=%b want 0", imem_req);
        end
        cyc();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== RPC) begin
            errs++;
            $display("FAIL first_req: req=%b addr=%h want 1 %h",
                     imem_req, imem_addr, RPC);
        end
        m_pc  = RPC;
        m_cnt = 32'd0;
        q.delete();
    endtask

    task automatic run_instr(
        input logic [31:0] data, input int waits, input int stalls,
        input bit b, input bit j, input bit z,
        input logic [31:0] exp_next, input string nm);
        sb_t e;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== m_pc) begin
            errs++;
            $display("FAIL %s_req: req=%b addr=%h want 1 %h",
                     nm, imem_req, imem_addr, m_pc);
        end
        for (int w = 0; w < waits; w++) begin
            imem_ready = 1'b0;
            branch = 1'b1; jump = 1'b1; zero = 1'b1;
            cyc();
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== m_pc ||
                instr_valid !== 1'b0) begin
                errs++;
                $display("FAIL %s_wait: req=%b addr=%h v=%b want 1 %h 0",
                         nm, imem_req, imem_addr, instr_valid, m_pc);
            end
        end
        branch = 1'b0; jump = 1'b0; zero = 1'b0;
        imem_ready = 1'b1;
        imem_rdata = data;
        q.push_back('{pc: m_pc, ins: data});
        cyc();
        imem_ready = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        for (int s = 0; s < stalls; s++) begin
            stall = 1'b1;
            imem_ready = 1'b1;
            imem_rdata = 32'h0BAD_0BAD;
            branch = b; jump = j; zero = z;
            cyc();
            checks++;
            if (instr_valid !== 1'b1 || instr !== data ||
                pc !== m_pc || instret !== m_cnt) begin
                errs++;
                $display("FAIL %s_stall: v=%b instr=%h pc=%h ir=%h want 1 %h %h %h",
                         nm, instr_valid, instr, pc, instret, data, m_pc, m_cnt);
            end
        end
        imem_ready = 1'b0;
        stall = 1'b0;
        branch = b; jump = j; zero = z;
        checks++;
        if (q.size() == 0) begin
            errs++;
            $display("FAIL %s_sb: scoreboard empty at retire", nm);
        end else begin
            e = q.pop_front();
            if (instr_valid !== 1'b1 || instr !== e.ins || pc !== e.pc) begin
                errs++;
                $display("FAIL %s_exec: v=%b instr=%h pc=%h want 1 %h %h",
                         nm, instr_valid, instr, pc, e.ins, e.pc);
            end
        end
        cyc();
        branch = 1'b0; jump = 1'b0; zero = 1'b0;
        m_pc = exp_next;
        m_cnt = m_cnt + 32'd1;
        checks++;
        if (pc !== m_pc || instret !== m_cnt) begin
            errs++;
            $display("FAIL %s_next: pc=%h ir=%h want %h %h",
                     nm, pc, instret, m_pc, m_cnt);
        end
        checks++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b1 ||
            pcplus4 !== m_pc + 32'd4) begin
            errs++;
            $display("FAIL %s_post: v=%b req=%b pc4=%h want 0 1 %h",
                     nm, instr_valid, imem_req, pcplus4, m_pc + 32'd4);
        end
    endtask

    task automatic test_sequential();
        run_instr(32'h2008_0005, 0, 0, 0, 0, 0, 32'h0040_0004, "seq0");
        checks++;
        if (pc2 !== 32'h0000_0000 || instret2 !== 32'd1) begin
            errs++;
            $display("FAIL pc_wrap: pc2=%h ir2=%h want 00000000 1",
                     pc2, instret2);
        end
        run_instr(32'h0000_0020, 0, 0, 0, 0, 0, 32'h0040_0008, "seq1");
    endtask

    task automatic test_branch();
        run_instr(32'h1109_FFFF, 0, 0, 1, 0, 1, 32'h0040_0008, "br_tk");
        run_instr(32'h1109_FFFF, 0, 0, 1, 0, 0, 32'h0040_000C, "br_nt");
    endtask

    task automatic test_jump();
        run_instr(32'h0810_0010, 0, 0, 0, 1, 0, 32'h0040_0040, "jmp");
        run_instr(32'h0810_0010, 0, 0, 1, 1, 1, 32'h0040_0040, "jmp_pri");
    endtask

    task automatic test_wait_stall();
        run_instr(32'h0123_4567, 3, 2, 0, 0, 0, 32'h0040_0044, "wst");
    endtask

    task automatic test_reset_in_fetch();
        reset = 1'b1;
        imem_ready = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        cyc();
        reset = 1'b0;
        imem_ready = 1'b0;
        checks++;
        if (instr !== 32'd0 || pc !== RPC || instret !== 32'd0) begin
            errs++;
            $display("FAIL rst_fetch: instr=%h pc=%h ir=%h want 0 %h 0",
                     instr, pc, instret, RPC);
        end
        checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            errs++;
            $display("FAIL rst_state: req=%b v=%b want 0 0",
                     imem_req, instr_valid);
        end
        q.delete();
        m_pc = RPC;
        m_cnt = 32'd0;
        cyc();
    endtask

    task automatic test_back_to_back();
        logic [31:0] ins, nx;
        bit b, j, z;
        for (int k = 0; k < 8; k++) begin
            ins = $urandom;
            b = 1'($urandom_range(0, 1));
            j = ($urandom_range(0, 3) == 0);
            z = 1'($urandom_range(0, 1));
            nx = model_next(m_pc, ins, b, j, z);
            run_instr(ins, $urandom_range(0, 1), $urandom_range(0, 1),
                      b, j, z, nx, "b2b");
        end
    endtask

    initial begin
        reset = 1'b1;
        imem_ready = 1'b0;
        imem_rdata = 32'd0;
        branch = 1'b0; jump = 1'b0; zero = 1'b0; stall = 1'b0;
        @(negedge clk);
        test_reset();
        test_sequential();
        test_branch();
        test_jump();
        test_wait_stall();
        test_reset_in_fetch();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch and PC-sequencing stage directly upstream of the main decoder in the MIPS core. It holds the PC, requests instructions from instruction memory over a ready handshake, and presents one instruction at a time to decode/execute. It consumes the decoder's branch/jump controls and the ALU zero flag to select the next PC.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; first fetch address.

Ports:
clk  input  1  core clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
imem_addr  output  32  instruction memory address; equals pc
imem_req  output  1  fetch request; high only in S_FETCH
imem_ready  input  1  imem_rdata valid this cycle; sampled only in S_FETCH
imem_rdata  input  32  instruction word from memory
instr  output  32  registered current instruction, to decoder/datapath
instr_valid  output  1  instr is executing this cycle
pc  output  32  address of instr
pcplus4  output  32  pc + 4 (combinational, mod 2^32)
branch  input  1  from main decoder; sampled when instr_valid=1
jump  input  1  from main decoder; sampled when instr_valid=1
zero  input  1  ALU zero flag; sampled when instr_valid=1
stall  input  1  datapath not done (e.g. data-memory wait); holds current instr
instret  output  32  retired-instruction counter

Behaviour:
- Reset (reset=1 at an edge, any state): state<=S_RESET, pc<=RESET_PC, instr<=0, instret<=0. Outputs during S_RESET: imem_req=0, instr_valid=0. Reset overrides every other input, including imem_ready and stall.
- States: S_RESET, S_FETCH, S_EXEC.
- S_RESET -> S_FETCH unconditionally next cycle; no fetch is issued in the reset-exit cycle.
- S_FETCH: imem_req=1, imem_addr=pc, held stable until accepted. If imem_ready=1, instr<=imem_rdata and state goes to S_EXEC; otherwise state stays S_FETCH. There is no timeout.
- S_EXEC: instr_valid=1; decoder/ALU outputs are combinational from instr in the same cycle.
  - stall=1: stay in S_EXEC; pc, instr and instret are unchanged.
  - stall=0: pc<=next_pc, instret<=instret+1 (wraps at 2^32), state goes to S_FETCH.
- next_pc priority, jump over branch:
  - jump=1: {pcplus4[31:28], instr[25:0], 2'b00}.
  - else branch=1 and zero=1: pcplus4 + (sign-extended instr[15:0] << 2), 32-bit mod 2^32.
  - else: pcplus4.
- Latency: minimum 2 cycles per instruction (1 fetch cycle with ready=1, 1 exec cycle), plus 1 per imem wait cycle and 1 per stall cycle.
- Boundaries:
  - imem_ready outside S_FETCH is ignored.
  - The memory contract requires ready to be low when req is low, so a stale ready cannot be captured after reset.
  - branch, jump and zero are ignored when instr_valid=0.
  - pc 32'hFFFF_FFFC sequential next_pc is 32'h0000_0000.
  - Branch target arithmetic wraps silently.
  - Unaligned targets cannot occur (low 2 bits always 00).

Test Plan:
1. RESET_PC=32'h0040_0000, pulse reset 2 cycles -> pc=0x00400000, imem_req=0 in first cycle after release, imem_req=1 with imem_addr=0x00400000 in the second.
2. ready=1 immediately with rdata=0x20080005, stall=0, branch=jump=0 -> instr_valid high exactly 1 cycle with instr=0x20080005, then pc=0x00400004, instret=1.
3. At pc=0x00400008, instr=0x1109FFFF, branch=1, zero=1 -> next pc=0x00400008. Repeat with zero=0 -> next pc=0x0040000C.
4. At pc=0x0040000C, instr=0x08100010, jump=1 -> next pc=0x00400040. Same with branch=1, zero=1 also high -> still 0x00400040.
5. imem_ready low 3 cycles -> imem_req and imem_addr held, instr_valid=0. Then stall=1 for 2 exec cycles -> instr and pc unchanged, instret unchanged until the stall=0 cycle.
6. reset asserted in S_FETCH in the same cycle imem_ready=1 with rdata=0xDEADBEEF -> instr=0, pc=RESET_PC, instret=0, state S_RESET.
